// File: rtl/xdispl_scan.sv
// ---------------------------------------------------------------------------
// xdispl_scan -- memory-mapped driver for a 4-digit multiplexed seven-segment
// display.
//
// The processor writes a 16-bit hex VALUE and a CTRL word through the shared
// sel-based peripheral port. The block then scans the four digits on its own,
// lighting each digit for REFRESH_DIV clock cycles in turn.
//
// Ports
//   clk       system clock
//   rst       synchronous, active-high reset
//   sel       module select; an access happens only while high
//   we        write enable (qualified by sel)
//   addr      register select: 0 = VALUE, 1 = CTRL
//   data_in   write data
//   data_out  registered readback, 0 in every cycle without a read
//   seg       segments, active-low, seg[6]=g .. seg[0]=a
//   dp        decimal point, active-low
//   an        digit anodes, active-low, an[0] = rightmost digit
//
// Registers
//   VALUE[15:0] : digit k shows nibble VALUE[4k+3:4k]
//   CTRL[8:0]   : [8] enable, [7:4] dp mask, [3:0] blank mask
//
// Bus handshake: there is no ready/stall. A write takes effect on the edge
// where sel & we are high; a read is requested on the edge where sel & !we
// are high and its data appears on data_out for exactly the next cycle.
// ---------------------------------------------------------------------------
module xdispl_scan #(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        we,
  input  logic        addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [15:0]      value_q;
  logic [15:0]      value_d;
  logic [8:0]       ctrl_q;
  logic [8:0]       ctrl_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [1:0]       idx_q;
  logic [1:0]       idx_d;

  logic             wr;
  logic             rd;
  logic             wrap;
  logic [3:0]       nib;
  logic [3:0]       blank;
  logic [3:0]       dpmask;
  logic             lit;
  logic [3:0]       an_d;
  logic [6:0]       seg_d;
  logic             dp_d;
  logic [15:0]      rdata;

  // Hex digit to active-low segment pattern (gfedcba).
  function automatic logic [6:0] hexdec(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    wr      = sel & we;
    rd      = sel & ~we;
    value_d = value_q;
    ctrl_d  = ctrl_q;
    if (wr) begin
      if (addr) ctrl_d  = data_in[8:0];
      else      value_d = data_in;
    end

    // The scan runs whether or not the display is enabled.
    wrap  = (cnt_q == CNT_LAST);
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
    idx_d = wrap ? idx_q + 2'd1 : idx_q;

    // The display is decoded from next-state index and register values, so
    // anodes, segments and dp all change together on one edge and a write
    // landing on a digit switch is shown immediately on the new digit.
    case (idx_d)
      2'd0:    nib = value_d[3:0];
      2'd1:    nib = value_d[7:4];
      2'd2:    nib = value_d[11:8];
      default: nib = value_d[15:12];
    endcase
    blank  = ctrl_d[3:0];
    dpmask = ctrl_d[7:4];
    lit    = ctrl_d[8] & ~blank[idx_d];
    an_d   = lit ? ~(4'b0001 << idx_d) : 4'hF;
    seg_d  = lit ? hexdec(nib) : 7'h7F;
    dp_d   = lit ? ~dpmask[idx_d] : 1'b1;

    rdata  = addr ? {7'b0, ctrl_q} : value_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q  <= '0;
      ctrl_q   <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      data_out <= '0;
      an       <= 4'hF;
      seg      <= 7'h7F;
      dp       <= 1'b1;
    end else begin
      value_q  <= value_d;
      ctrl_q   <= ctrl_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      data_out <= rd ? rdata : '0;
      an       <= an_d;
      seg      <= seg_d;
      dp       <= dp_d;
    end
  end

endmodule

// File: tb/tb_xdispl_scan.sv
// ---------------------------------------------------------------------------
// tb_xdispl_scan -- self-checking bench for xdispl_scan (REFRESH_DIV = 4).
// A cycle-level model tracks registers and elapsed cycles since reset; the
// lit digit is derived arithmetically from the cycle count. Directed steps
// add hand-computed literal checks on top of the per-cycle comparison.
// ---------------------------------------------------------------------------
module tb_xdispl_scan;

  localparam int DIV = 4;

  logic        clk;
  logic        rst;
  logic        sel;
  logic        we;
  logic        addr;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  xdispl_scan #(.REFRESH_DIV(DIV), .CNT_W(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .sel      (sel),
    .we       (we),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .seg      (seg),
    .dp       (dp),
    .an       (an)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters and scoreboard ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [6:0]  hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [15:0] m_value;
  logic [8:0]  m_ctrl;
  int          m_cycles;
  logic [15:0] m_dout;
  bit          started = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_value  = '0;
        m_ctrl   = '0;
        m_cycles = 0;
        m_dout   = '0;
        started  = 1'b1;
      end else begin
        m_cycles = m_cycles + 1;
        m_dout   = (sel && !we) ? (addr ? {7'b0, m_ctrl} : m_value) : 16'h0;
        if (sel && we) begin
          if (addr) m_ctrl  = data_in[8:0];
          else      m_value = data_in;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin : compare
    int         k;
    logic       lit;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    forever begin
      @(negedge clk);
      if (started) begin
        k     = (m_cycles / DIV) % 4;
        lit   = m_ctrl[8] && !m_ctrl[k];
        e_an  = lit ? (4'hF & ~(4'b0001 << k)) : 4'hF;
        e_seg = lit ? hex_tab[(m_value >> (4 * k)) & 16'hF] : 7'h7F;
        e_dp  = lit ? ~m_ctrl[4 + k] : 1'b1;
        check("model_an",   16'(an),   16'(e_an));
        check("model_seg",  16'(seg),  16'(e_seg));
        check("model_dp",   16'(dp),   16'(e_dp));
        check("model_dout", data_out,  m_dout);
      end
    end
  end

  // ---------------- driver tasks (called just after a negedge) ----------------
  task automatic bus_idle();
    sel     = 1'b0;
    we      = 1'b0;
    addr    = 1'b0;
    data_in = 16'h0;
  endtask

  task automatic write_reg(input logic a, input logic [15:0] d);
    sel = 1'b1; we = 1'b1; addr = a; data_in = d;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic read_check(input string name, input logic a, input logic [15:0] exp);
    logic [15:0] e;
    sel = 1'b1; we = 1'b0; addr = a;
    exp_q.push_back(exp);
    @(negedge clk);
    bus_idle();
    e = exp_q.pop_front();
    check(name, data_out, e);
    @(negedge clk);
    check({name, "_clear"}, data_out, 16'h0);
  endtask

  task automatic wait_an(input string name, input logic [3:0] target);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (an == target) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({"wait_", name}, 16'(found), 16'h1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int bad;
    rst = 1'b1;
    bus_idle();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Idle after reset: display dark, no readback.
    repeat (20) @(negedge clk);
    check("idle_an",   16'(an),  16'hF);
    check("idle_seg",  16'(seg), 16'h7F);
    check("idle_dp",   16'(dp),  16'h1);
    check("idle_dout", data_out, 16'h0);

    // Plain scan of 1234: digit0=4, digit1=3, digit2=2, digit3=1.
    write_reg(1'b0, 16'h1234);
    write_reg(1'b1, 16'h0100);
    wait_an("d0", 4'hE); check("scan_seg0", 16'(seg), 16'h19); check("scan_dp0", 16'(dp), 16'h1);
    wait_an("d1", 4'hD); check("scan_seg1", 16'(seg), 16'h30);
    wait_an("d2", 4'hB); check("scan_seg2", 16'(seg), 16'h24);
    wait_an("d3", 4'h7); check("scan_seg3", 16'(seg), 16'h79);

    // Blank digits 1 and 3, decimal points on 0 and 2.
    write_reg(1'b1, 16'h015A);
    wait_an("m0", 4'hE); check("mask_seg0", 16'(seg), 16'h19); check("mask_dp0", 16'(dp), 16'h0);
    wait_an("m2", 4'hB); check("mask_seg2", 16'(seg), 16'h24); check("mask_dp2", 16'(dp), 16'h0);
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (an == 4'hD || an == 4'h7) bad++;
      @(negedge clk);
    end
    check("mask_blanked", 16'(bad), 16'h0);

    // Readback of both registers.
    write_reg(1'b0, 16'hABCD);
    read_check("rd_value", 1'b0, 16'hABCD);
    read_check("rd_ctrl",  1'b1, 16'h015A);

    // CTRL upper bits are not stored.
    write_reg(1'b1, 16'hFE5A);
    read_check("rd_ctrl_mask", 1'b1, 16'h005A);
    write_reg(1'b1, 16'h015A);

    // we without sel must not write.
    sel = 1'b0; we = 1'b1; addr = 1'b0; data_in = 16'hFFFF;
    @(negedge clk);
    bus_idle();
    read_check("rd_nosel", 1'b0, 16'hABCD);

    // Reset while digit 2 is lit, colliding with a VALUE write.
    wait_an("pre_rst", 4'hB);
    rst = 1'b1; sel = 1'b1; we = 1'b1; addr = 1'b0; data_in = 16'hFFFF;
    @(negedge clk);
    rst = 1'b0;
    bus_idle();
    check("rst_an",   16'(an),  16'hF);
    check("rst_seg",  16'(seg), 16'h7F);
    check("rst_dp",   16'(dp),  16'h1);
    check("rst_dout", data_out, 16'h0);
    read_check("rst_value", 1'b0, 16'h0000);
    read_check("rst_ctrl",  1'b1, 16'h0000);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
